// File: rtl/reg16_arbiter.sv
// reg16_arbiter: round-robin write arbiter and sequencer for one shared 16-bit register.
// Ports:
//   clk      rising-edge system clock
//   reset    asynchronous active-high reset
//   req      per-requester write request, bit i = requester i
//   wdata    per-requester write data, requester i on wdata[16i+15:16i]
//   grant    one-hot, requester whose write is in flight (WRITE and DONE)
//   ack      one-hot single-cycle pulse when the write has committed
//   busy     high whenever the sequencer is not idle
//   reg_out  current contents of the shared register
module reg16bit (
  input  logic        clk,
  input  logic        load,
  input  logic [15:0] d,
  output logic [15:0] q
);
  always_ff @(posedge clk)
    if (load) q <= d;
endmodule

module reg16_arbiter (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req,
  input  logic [63:0] wdata,
  output logic [3:0]  grant,
  output logic [3:0]  ack,
  output logic        busy,
  output logic [15:0] reg_out
);
  typedef enum logic [1:0] {CLEAR, IDLE, WRITE, DONE} state_t;
  state_t      state;
  logic [1:0]  ptr;
  logic [1:0]  win;
  logic [15:0] hold;
  logic        load;
  logic [15:0] d;
  // Scan from farthest to nearest so the requester closest after ptr wins last;
  // offset 4 wraps to ptr itself, giving the last winner the lowest priority.
  always_comb begin
    win = ptr;
    for (int k = 4; k >= 1; k--)
      if (req[ptr + 2'(k)]) win = ptr + 2'(k);
  end
  assign load = (state == CLEAR) || (state == WRITE);
  assign d    = (state == WRITE) ? hold : 16'h0000;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= CLEAR;
      ptr   <= 2'd3;
      hold  <= '0;
      grant <= '0;
      ack   <= '0;
      busy  <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        IDLE: if (|req) begin
          state <= WRITE;
          ptr   <= win;
          hold  <= wdata[{win, 4'b0000} +: 16];
          grant <= 4'b0001 << win;
          busy  <= 1'b1;
        end
        WRITE: begin
          state <= DONE;
          ack   <= grant;
        end
        default: begin
          state <= IDLE;
          grant <= '0;
          ack   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  reg16bit u_reg (
    .clk  (clk),
    .load (load),
    .d    (d),
    .q    (reg_out)
  );
endmodule

// File: doc/reg16_arbiter.md
# reg16_arbiter

Write-access arbiter and sequencer for one shared 16-bit storage register (an internal `reg16bit` instance). It serves four requesters with a round-robin req/ack handshake. The arbiter latches the winner's data and drives the register's `load` for exactly one cycle. It also performs a clearing write after reset, so the stored value is defined. It sits between producer blocks and any shared 16-bit state, such as a status or mailbox word, in the memory subsystem.

## Interface
- Parameters: none. Requester count is fixed at 4 and data width at 16.
- `clk`  in  1  system clock. Every state element updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req`  in  4  per-requester write request. Bit i belongs to requester i.
- `wdata`  in  64  per-requester write data. Requester i uses `wdata[16i+15:16i]`.
- `grant`  out  4  one-hot. Marks the requester whose write is in flight.
- `ack`  out  4  one-hot, one-cycle pulse. Bit i pulses when requester i's write has committed.
- `busy`  out  1  high whenever the state is not IDLE.
- `reg_out`  out  16  current contents of the shared register.

## Operation
- **States:**
  - CLEAR: reset state. Drives `load`=1 with data 0x0000 for one cycle, then goes to IDLE.
  - IDLE: arbitrates.
  - WRITE: drives `load`=1 with the latched data for one cycle, then goes to DONE.
  - DONE: pulses `ack` to the winner, then goes to IDLE.
- **Arbitration in IDLE:**
  - If `req` != 0, pick the winner by round-robin.
  - The search starts at `ptr`+1 (mod 4) and scans upward with wrap. `ptr` is the index of the last winner.
  - On a win: latch the winner's `wdata` slice into a 16-bit hold register, set `ptr` = winner, set `grant` one-hot, and go to WRITE.
  - If `req` == 0, stay in IDLE with `grant`=0.
- **Grant:** `grant` is held through WRITE and DONE and cleared on return to IDLE.
- **After the grant cycle:**
  - Data is taken only from the hold register. Changes to `wdata` or `req` after the grant cycle do not affect the write.
  - If the winner drops `req` during WRITE or DONE, the write still completes and `ack` still pulses.
- **Re-arbitration:** a requester that keeps `req` high after its `ack` is treated as a new request. It is arbitrated in the next IDLE cycle.
- **Fairness:** with all four requesting continuously, grants go 0,1,2,3,0,... Each requester is served at least once every 12 cycles.
- **`load` source:** the internal register's `load` is high only in CLEAR and WRITE. No other path drives `load`.
- **Data width:** no arithmetic. Data passes through unmodified at 16 bits.

## Timing
- **Reset values** (while `reset` is high): `grant`=0, `ack`=0, `busy`=1, state=CLEAR, `ptr`=3, hold=0. `reg_out` is undefined until the CLEAR write lands.
- **Startup:** the first rising edge after `reset` falls commits 0x0000 and enters IDLE. From the next cycle `reg_out`=0x0000 and `busy`=0.
- **Write sequence** (a request seen in IDLE at edge E0):
  - E0: grant latched. WRITE is entered.
  - E1: register captures the data. DONE is entered. `reg_out` shows the new value after E1.
  - E2: IDLE is entered.
  - `ack` is high for the one cycle between E1 and E2.
- **Latency and throughput:**
  - Request to `ack`: 2 cycles.
  - Request to `reg_out` update: 2 cycles.
  - Back-to-back throughput: one write per 3 cycles.
- **Reset mid-operation:** `reset` asserted in WRITE or DONE aborts immediately. No `ack` is issued, `grant` clears, `ptr` returns to 3, and CLEAR runs again.
- **Reset landing with the capture edge:** if reset asserts in the same cycle as the WRITE capture edge, the register value is don't-care until CLEAR finishes.
- **Request arriving during WRITE or DONE:** not sampled. It waits for the next IDLE.
- **Simultaneous requests:** exactly one grant per arbitration. Losers keep waiting.

## Test plan
- **Reset/clear:** hold `reset` 3 cycles, then release with `req`=0 → `busy`=1 for 1 cycle, then 0. `reg_out`=0x0000. `grant` and `ack` stay 0.
- **Single write:** `req`=0001, `wdata[15:0]`=0xBEEF for 1 cycle only → `grant`=0001 for 2 cycles. `ack`=0001 two cycles after the request. `reg_out`=0xBEEF thereafter.
- **Data latch:** `req`=0100 with data 0x1234. Change that slice to 0xFFFF and drop `req` one cycle later → `ack`[2] still pulses. `reg_out`=0x1234.
- **Round-robin:** `req`=1111 held, slice i = 0x000i → ack order 0,1,2,3,0. `reg_out` steps 0x0000,0x0001,0x0002,0x0003,0x0000, one write every 3 cycles.
- **Pointer wrap:** serve requester 2, then assert `req`=1011 → order is 3, 0, 1.
- **Reset mid-write:** assert `reset` during DONE of a write to 0xAAAA → no `ack` is seen. After release, `reg_out`=0x0000 and the next `req`=1111 grants requester 0 first.
